// File: rtl/intmul_pkg.sv
// ============================================================================
// Module : intmul_pkg
// Brief  : Shared helpers, default sizing constants and the product type
//          for the pipelined integer multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package intmul_pkg;

  localparam int W_DEF          = 255;
  localparam int LIMB_A_DEF     = 17;
  localparam int LIMB_B_DEF     = 24;
  localparam int ADD_STAGES_DEF = 2;
  localparam int TAG_W_DEF      = 4;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic longint ipow(input int b, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * longint'(b);
    return r;
  endfunction

  // Smallest g with g**stages >= na, i.e. ceil(na^(1/stages)).
  function automatic int calc_g(input int na, input int stages);
    int g;
    g = na;
    for (int c = na; c >= 1; c--)
      if (ipow(c, stages) >= longint'(na)) g = c;
    return g;
  endfunction

  // Number of terms left after lvl adder-tree levels (lvl=0: the row sums).
  function automatic int terms_after(input int na, input int g, input int lvl);
    int t;
    t = na;
    for (int i = 0; i < lvl; i++) t = ceil_div(t, g);
    return t;
  endfunction

  // Term index where level lvl's outputs start in the flattened tree bus.
  function automatic int term_offset(input int na, input int g, input int lvl);
    int off;
    off = 0;
    for (int m = 0; m < lvl; m++) off = off + terms_after(na, g, m);
    return off;
  endfunction

  localparam int NA_DEF = ceil_div(W_DEF, LIMB_A_DEF);
  localparam int NB_DEF = ceil_div(W_DEF, LIMB_B_DEF);
  localparam int G_DEF  = calc_g(NA_DEF, ADD_STAGES_DEF);

  typedef logic [2*W_DEF-1:0] prod_t;

endpackage

`default_nettype wire

// File: rtl/intmul_add_level.sv
// ============================================================================
// Module : intmul_add_level
// Brief  : One registered adder-tree level: sums groups of GRP terms, carrying
//          valid and tag alongside. Data and tag hold when the input is idle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module intmul_add_level
  import intmul_pkg::*;
#(
  parameter int WD    = 510,
  parameter int N_IN  = 4,
  parameter int GRP   = 4,
  parameter int TAG_W = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             in_valid,
  input  logic [TAG_W-1:0]                 in_tag,
  input  logic [N_IN*WD-1:0]               in_terms,
  output logic                             out_valid,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [ceil_div(N_IN,GRP)*WD-1:0] out_terms
);

  localparam int N_OUT = ceil_div(N_IN, GRP);

  logic                  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [N_OUT*WD-1:0]   terms_q, terms_d;
  logic [N_OUT*WD-1:0]   sums;
  logic [WD-1:0]         acc;

  always_comb begin
    sums = '0;
    acc  = '0;
    for (int o = 0; o < N_OUT; o++) begin
      acc = '0;
      for (int k = 0; k < GRP; k++)
        if (o*GRP + k < N_IN) acc = acc + in_terms[(o*GRP + k)*WD +: WD];
      sums[o*WD +: WD] = acc;
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    terms_d = terms_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) begin
        tag_d   = in_tag;
        terms_d = sums;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      terms_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      terms_q <= terms_d;
    end
  end

  assign out_valid = valid_q;
  assign out_tag   = tag_q;
  assign out_terms = terms_q;

endmodule

`default_nettype wire

// File: rtl/pipelined_intmul.sv
// ============================================================================
// Module : pipelined_intmul
// Brief  : Fully pipelined unsigned WxW multiplier: operand capture, limb
//          partial products, ADD_STAGES registered adder-tree levels.
//          Define INTMUL_SQR_EN to add the in_sqr squaring input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipelined_intmul
  import intmul_pkg::*;
#(
  parameter int W          = 255,
  parameter int LIMB_A     = 17,
  parameter int LIMB_B     = 24,
  parameter int ADD_STAGES = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
`ifdef INTMUL_SQR_EN
  input  logic             in_sqr,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int NA       = ceil_div(W, LIMB_A);
  localparam int NB       = ceil_div(W, LIMB_B);
  localparam int G        = calc_g(NA, ADD_STAGES);
  localparam int PW       = 2*W;
  localparam int PPW      = LIMB_A + LIMB_B;
  localparam int TOT      = term_offset(NA, G, ADD_STAGES + 1);
  localparam int OFF_LAST = term_offset(NA, G, ADD_STAGES);

  logic                    en;
  logic [W-1:0]            b_sel;
  logic                    v0_q, v0_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]        tag0_q, tag0_d;
  logic                    v1_q, v1_d;
  logic [NA*NB*PPW-1:0]    pp_q, pp_d;
  logic [TAG_W-1:0]        tag1_q, tag1_d;
  logic [NA*LIMB_A-1:0]    a_pad;
  logic [NB*LIMB_B-1:0]    b_pad;
  logic [NA*PW-1:0]        rows;
  logic [PW-1:0]           row_acc;

  // Region 0 holds the row sums; region l holds the outputs of tree level l.
  logic [TOT*PW-1:0]              chain;
  logic [ADD_STAGES:0]            lvl_valid;
  logic [(ADD_STAGES+1)*TAG_W-1:0] lvl_tag;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

`ifdef INTMUL_SQR_EN
  assign b_sel = in_sqr ? in_a : in_b;
`else
  assign b_sel = in_b;
`endif

  always_comb begin
    v0_d   = v0_q;
    a_d    = a_q;
    b_d    = b_q;
    tag0_d = tag0_q;
    if (en) begin
      v0_d = in_valid;
      if (in_valid) begin
        a_d    = in_a;
        b_d    = b_sel;
        tag0_d = in_tag;
      end
    end
  end

  // Top limbs are zero-padded up to a whole limb.
  assign a_pad = (NA*LIMB_A)'(a_q);
  assign b_pad = (NB*LIMB_B)'(b_q);

  always_comb begin
    v1_d   = v1_q;
    pp_d   = pp_q;
    tag1_d = tag1_q;
    if (en) begin
      v1_d = v0_q;
      if (v0_q) begin
        tag1_d = tag0_q;
        for (int i = 0; i < NA; i++)
          for (int j = 0; j < NB; j++)
            pp_d[(i*NB + j)*PPW +: PPW] = PPW'(a_pad[i*LIMB_A +: LIMB_A]) *
                                          PPW'(b_pad[j*LIMB_B +: LIMB_B]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag0_q <= '0;
      v1_q   <= 1'b0;
      pp_q   <= '0;
      tag1_q <= '0;
    end else begin
      v0_q   <= v0_d;
      a_q    <= a_d;
      b_q    <= b_d;
      tag0_q <= tag0_d;
      v1_q   <= v1_d;
      pp_q   <= pp_d;
      tag1_q <= tag1_d;
    end
  end

  always_comb begin
    rows    = '0;
    row_acc = '0;
    for (int i = 0; i < NA; i++) begin
      row_acc = '0;
      for (int j = 0; j < NB; j++)
        row_acc = row_acc +
                  (PW'(pp_q[(i*NB + j)*PPW +: PPW]) << (i*LIMB_A + j*LIMB_B));
      rows[i*PW +: PW] = row_acc;
    end
  end

  assign chain[NA*PW-1:0]       = rows;
  assign lvl_valid[0]           = v1_q;
  assign lvl_tag[TAG_W-1:0]     = tag1_q;

  for (genvar l = 1; l <= ADD_STAGES; l++) begin : g_lvl
    localparam int N_IN    = terms_after(NA, G, l-1);
    localparam int GRP     = (l == ADD_STAGES) ? N_IN : G;
    localparam int N_OUT   = ceil_div(N_IN, GRP);
    localparam int OFF_IN  = term_offset(NA, G, l-1);
    localparam int OFF_OUT = term_offset(NA, G, l);

    intmul_add_level #(
      .WD    (PW),
      .N_IN  (N_IN),
      .GRP   (GRP),
      .TAG_W (TAG_W)
    ) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (lvl_valid[l-1]),
      .in_tag    (lvl_tag[(l-1)*TAG_W +: TAG_W]),
      .in_terms  (chain[OFF_IN*PW +: N_IN*PW]),
      .out_valid (lvl_valid[l]),
      .out_tag   (lvl_tag[l*TAG_W +: TAG_W]),
      .out_terms (chain[OFF_OUT*PW +: N_OUT*PW])
    );
  end

  assign out_valid = lvl_valid[ADD_STAGES];
  assign out_tag   = lvl_tag[ADD_STAGES*TAG_W +: TAG_W];
  assign out_p     = chain[OFF_LAST*PW +: PW];
  assign busy      = v0_q | (|lvl_valid);

endmodule

`default_nettype wire
